// File: rtl/eth_pkg.sv
// Shared types and constants for the GMII receive decapsulation path.
// Also holds the byte-wide reflected CRC-32 step used by crc32_rx.
package eth_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DST,
        SRC,
        TYPE,
        PAYLOAD,
        DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam int DST_LEN   = 6;
    localparam int SRC_LEN   = 6;
    localparam int TYPE_LEN  = 2;
    localparam int FCS_LEN   = 4;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    // One byte through the reflected CRC, least significant bit first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_rx.sv
// Registered byte-wide CRC-32 accumulator; init has priority over en.
// The output is the register itself, so it reflects all bytes accepted so far.
module crc32_rx
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/decapsulation.sv
// GMII receive decapsulator: strips preamble/SFD/header, filters on destination,
// hides the FCS behind a 4-byte delay line and reports a good/bad verdict at frame end.
module decapsulation
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h40ac14dfbb66,
    parameter bit          PROMISC  = 1'b0,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1522
) (
    input  logic        eth_rx_clk,
    input  logic        arst_n,
    input  logic        eth_rx_dv,
    input  logic        eth_rx_er,
    input  logic [7:0]  eth_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_ethertype,
    output logic [15:0] crc_err_cnt
);

    localparam int LEN_W   = $clog2(MAX_LEN + 2);
    localparam int DLY_AW  = $clog2(FCS_LEN);
    localparam int FILL_W  = DLY_AW + 1;

    localparam logic [LEN_W-1:0]  LEN_SAT   = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [2:0]        DST_LAST  = 3'(DST_LEN - 1);
    localparam logic [2:0]        SRC_LAST  = 3'(SRC_LEN - 1);
    localparam logic [2:0]        TYPE_LAST = 3'(TYPE_LEN - 1);
    localparam logic [FILL_W-1:0] DLY_FULL  = FILL_W'(FCS_LEN);

    state_t             state_q, state_d;
    logic [2:0]         hdr_cnt_q, hdr_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               dst_match_q, dst_match_d;
    logic               dst_bcast_q, dst_bcast_d;
    logic [47:0]        src_shadow_q, src_shadow_d;
    logic [15:0]        type_shadow_q, type_shadow_d;
    logic [7:0]         dly_q [FCS_LEN];
    logic [7:0]         dly_d [FCS_LEN];
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               sof_sent_q, sof_sent_d;

    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_sof_q, rx_sof_d;
    logic               rx_eof_q, rx_eof_d;
    logic               rx_good_q, rx_good_d;
    logic [47:0]        rx_src_mac_q, rx_src_mac_d;
    logic [15:0]        rx_ethertype_q, rx_ethertype_d;
    logic [15:0]        crc_err_cnt_q, crc_err_cnt_d;

    logic               crc_init;
    logic               crc_en;
    logic [31:0]        crc_val;
    logic               crc_ok;
    logic [LEN_W-1:0]   len_inc;
    logic [5:0]         mac_sh_amt;
    logic [47:0]        mac_shift;
    logic [7:0]         mac_byte;

    crc32_rx u_crc (
        .clk    (eth_rx_clk),
        .arst_n (arst_n),
        .init   (crc_init),
        .en     (crc_en),
        .data   (eth_rxd),
        .crc    (crc_val)
    );

    assign crc_ok     = (crc_val == CRC_RESIDUE);
    assign len_inc    = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
    // Destination bytes arrive most significant first.
    assign mac_sh_amt = {DST_LAST - hdr_cnt_q, 3'b000};
    assign mac_shift  = MAC_ADDR >> mac_sh_amt;
    assign mac_byte   = mac_shift[7:0];

    always_comb begin
        state_d        = state_q;
        hdr_cnt_d      = hdr_cnt_q;
        len_d          = len_q;
        dst_match_d    = dst_match_q;
        dst_bcast_d    = dst_bcast_q;
        src_shadow_d   = src_shadow_q;
        type_shadow_d  = type_shadow_q;
        dly_d          = dly_q;
        fill_d         = fill_q;
        sof_sent_d     = sof_sent_q;
        rx_data_d      = 8'h00;
        rx_valid_d     = 1'b0;
        rx_sof_d       = 1'b0;
        rx_eof_d       = 1'b0;
        rx_good_d      = 1'b0;
        rx_src_mac_d   = rx_src_mac_q;
        rx_ethertype_d = rx_ethertype_q;
        crc_err_cnt_d  = crc_err_cnt_q;
        crc_init       = 1'b0;
        crc_en         = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (!eth_rx_dv) state_d = IDLE;
            end

            IDLE, PREAMBLE: begin
                if (!eth_rx_dv) begin
                    state_d = IDLE;
                end else if (eth_rx_er) begin
                    state_d = DROP;
                end else if (eth_rxd == SFD_BYTE) begin
                    state_d     = DST;
                    crc_init    = 1'b1;
                    len_d       = '0;
                    hdr_cnt_d   = '0;
                    dst_match_d = 1'b1;
                    dst_bcast_d = 1'b1;
                end else if (eth_rxd == PREAMBLE_BYTE) begin
                    state_d = PREAMBLE;
                end else begin
                    state_d = DROP;
                end
            end

            DST: begin
                if (!eth_rx_dv) begin
                    state_d = IDLE;
                end else if (eth_rx_er) begin
                    state_d = DROP;
                end else begin
                    crc_en      = 1'b1;
                    len_d       = len_inc;
                    hdr_cnt_d   = hdr_cnt_q + 3'd1;
                    dst_match_d = dst_match_q && (eth_rxd == mac_byte);
                    dst_bcast_d = dst_bcast_q && (eth_rxd == BCAST_ADDR[7:0]);
                    if (hdr_cnt_q == DST_LAST) begin
                        hdr_cnt_d = '0;
                        state_d   = (PROMISC || dst_match_d || dst_bcast_d) ? SRC : DROP;
                    end
                end
            end

            SRC: begin
                if (!eth_rx_dv) begin
                    state_d = IDLE;
                end else if (eth_rx_er) begin
                    state_d = DROP;
                end else begin
                    crc_en       = 1'b1;
                    len_d        = len_inc;
                    hdr_cnt_d    = hdr_cnt_q + 3'd1;
                    src_shadow_d = {src_shadow_q[39:0], eth_rxd};
                    if (hdr_cnt_q == SRC_LAST) begin
                        hdr_cnt_d = '0;
                        state_d   = TYPE;
                    end
                end
            end

            TYPE: begin
                if (!eth_rx_dv) begin
                    state_d = IDLE;
                end else if (eth_rx_er) begin
                    state_d = DROP;
                end else begin
                    crc_en        = 1'b1;
                    len_d         = len_inc;
                    hdr_cnt_d     = hdr_cnt_q + 3'd1;
                    type_shadow_d = {type_shadow_q[7:0], eth_rxd};
                    if (hdr_cnt_q == TYPE_LAST) begin
                        hdr_cnt_d  = '0;
                        fill_d     = '0;
                        sof_sent_d = 1'b0;
                        state_d    = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (!eth_rx_dv) begin
                    // Normal end: the four bytes still in the delay line are the FCS.
                    state_d = IDLE;
                    fill_d  = '0;
                    if (sof_sent_q) begin
                        rx_eof_d  = 1'b1;
                        rx_good_d = crc_ok && (len_q >= MIN_LEN_L);
                        if (!crc_ok && (crc_err_cnt_q != 16'hFFFF)) begin
                            crc_err_cnt_d = crc_err_cnt_q + 16'd1;
                        end
                    end
                end else if (eth_rx_er || (len_inc > MAX_LEN_L)) begin
                    state_d = DROP;
                    fill_d  = '0;
                    if (sof_sent_q) begin
                        rx_eof_d  = 1'b1;
                        rx_good_d = 1'b0;
                    end
                end else begin
                    crc_en = 1'b1;
                    len_d  = len_inc;
                    if (fill_q < DLY_FULL) begin
                        dly_d[fill_q[DLY_AW-1:0]] = eth_rxd;
                        fill_d = fill_q + 1'b1;
                    end else begin
                        rx_data_d  = dly_q[0];
                        rx_valid_d = 1'b1;
                        for (int i = 0; i < FCS_LEN - 1; i++) begin
                            dly_d[i] = dly_q[i+1];
                        end
                        dly_d[FCS_LEN-1] = eth_rxd;
                        if (!sof_sent_q) begin
                            rx_sof_d       = 1'b1;
                            sof_sent_d     = 1'b1;
                            rx_src_mac_d   = src_shadow_q;
                            rx_ethertype_d = type_shadow_q;
                        end
                    end
                end
            end

            DROP: begin
                if (!eth_rx_dv) state_d = IDLE;
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge eth_rx_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= WAIT_IDLE;
            hdr_cnt_q      <= '0;
            len_q          <= '0;
            dst_match_q    <= 1'b0;
            dst_bcast_q    <= 1'b0;
            src_shadow_q   <= '0;
            type_shadow_q  <= '0;
            for (int i = 0; i < FCS_LEN; i++) begin
                dly_q[i] <= '0;
            end
            fill_q         <= '0;
            sof_sent_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_sof_q       <= 1'b0;
            rx_eof_q       <= 1'b0;
            rx_good_q      <= 1'b0;
            rx_src_mac_q   <= '0;
            rx_ethertype_q <= '0;
            crc_err_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            hdr_cnt_q      <= hdr_cnt_d;
            len_q          <= len_d;
            dst_match_q    <= dst_match_d;
            dst_bcast_q    <= dst_bcast_d;
            src_shadow_q   <= src_shadow_d;
            type_shadow_q  <= type_shadow_d;
            for (int i = 0; i < FCS_LEN; i++) begin
                dly_q[i] <= dly_d[i];
            end
            fill_q         <= fill_d;
            sof_sent_q     <= sof_sent_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_sof_q       <= rx_sof_d;
            rx_eof_q       <= rx_eof_d;
            rx_good_q      <= rx_good_d;
            rx_src_mac_q   <= rx_src_mac_d;
            rx_ethertype_q <= rx_ethertype_d;
            crc_err_cnt_q  <= crc_err_cnt_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_sof       = rx_sof_q;
    assign rx_eof       = rx_eof_q;
    assign rx_good      = rx_good_q;
    assign rx_src_mac   = rx_src_mac_q;
    assign rx_ethertype = rx_ethertype_q;
    assign crc_err_cnt  = crc_err_cnt_q;

endmodule

// File: tb/tb_decapsulation.sv
// Scoreboarded bench for the receive decapsulator; a second instance with
// PROMISC=1 shares the same GMII stream for the promiscuous-mode case.
module tb_decapsulation;

    localparam logic [47:0] MAC     = 48'h40ac14dfbb66;
    localparam int          MIN_LEN = 64;
    localparam int          MAX_LEN = 1522;

    logic        eth_rx_clk = 1'b0;
    logic        arst_n     = 1'b0;
    logic        eth_rx_dv  = 1'b0;
    logic        eth_rx_er  = 1'b0;
    logic [7:0]  eth_rxd    = 8'h00;

    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_good;
    logic [47:0] rx_src_mac;
    logic [15:0] rx_ethertype, crc_err_cnt;

    logic [7:0]  p_rx_data;
    logic        p_rx_valid, p_rx_sof, p_rx_eof, p_rx_good;
    logic [47:0] p_rx_src_mac;
    logic [15:0] p_rx_ethertype, p_crc_err_cnt;

    decapsulation #(.MAC_ADDR(MAC), .PROMISC(1'b0), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .eth_rx_clk(eth_rx_clk), .arst_n(arst_n), .eth_rx_dv(eth_rx_dv), .eth_rx_er(eth_rx_er),
        .eth_rxd(eth_rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_good(rx_good), .rx_src_mac(rx_src_mac),
        .rx_ethertype(rx_ethertype), .crc_err_cnt(crc_err_cnt)
    );

    decapsulation #(.MAC_ADDR(MAC), .PROMISC(1'b1), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut_p (
        .eth_rx_clk(eth_rx_clk), .arst_n(arst_n), .eth_rx_dv(eth_rx_dv), .eth_rx_er(eth_rx_er),
        .eth_rxd(eth_rxd), .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_sof(p_rx_sof),
        .rx_eof(p_rx_eof), .rx_good(p_rx_good), .rx_src_mac(p_rx_src_mac),
        .rx_ethertype(p_rx_ethertype), .crc_err_cnt(p_crc_err_cnt)
    );

    always #5 eth_rx_clk = ~eth_rx_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
    } exp_t;

    exp_t       exp_q [$];
    logic       eof_q [$];
    logic [7:0] fr    [$];
    bit         fr_bad;
    int         vectors     = 0;
    int         miscompares = 0;
    bit         mon_en      = 1'b1;
    int         p_sof_cnt   = 0;
    int         p_good_cnt  = 0;
    int         act_cnt     = 0;
    exp_t       mon_e;
    logic       mon_g;

    // Output monitor: pops the scoreboard whenever the DUT emits a byte or an end marker.
    always @(negedge eth_rx_clk) begin
        if (mon_en) begin
            if (rx_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL mon_extra_byte: got data %h sof %b, required no byte", rx_data, rx_sof);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rx_data !== mon_e.d || rx_sof !== mon_e.sof) begin
                        miscompares++;
                        $display("FAIL mon_byte: got data %h sof %b, required data %h sof %b",
                                 rx_data, rx_sof, mon_e.d, mon_e.sof);
                    end else begin
                        $display("byte %h sof %b ok", rx_data, rx_sof);
                    end
                end
            end else if (rx_sof !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL mon_sof_alone: got rx_sof %b with rx_valid 0, required 0", rx_sof);
            end
            if (rx_eof) begin
                vectors++;
                if (eof_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL mon_extra_eof: got rx_eof good %b, required no eof", rx_good);
                end else begin
                    mon_g = eof_q.pop_front();
                    if (rx_good !== mon_g || rx_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL mon_eof: got good %b valid %b, required good %b valid 0",
                                 rx_good, rx_valid, mon_g);
                    end else begin
                        $display("eof good %b ok", rx_good);
                    end
                end
            end
        end
        if (p_rx_sof) p_sof_cnt++;
        if (p_rx_eof && p_rx_good) p_good_cnt++;
        if (rx_valid || rx_sof || rx_eof) act_cnt++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Frame from first destination byte through FCS, payload bytes = index.
    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] ety,
                         input int plen, input bit flip);
        logic [31:0] c;
        logic [7:0]  last;
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(src[i*8 +: 8]);
        fr.push_back(ety[15:8]);
        fr.push_back(ety[7:0]);
        for (int i = 0; i < plen; i++) fr.push_back(8'(i));
        c = 32'hFFFF_FFFF;
        foreach (fr[i]) c = crc_upd(c, fr[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(c[k*8 +: 8]);
        if (flip) begin
            last = fr[fr.size()-1] ^ 8'h01;
            fr[fr.size()-1] = last;
        end
        fr_bad = flip;
    endtask

    task automatic drive(input logic [7:0] b, input logic er);
        @(posedge eth_rx_clk);
        #1;
        eth_rx_dv = 1'b1;
        eth_rxd   = b;
        eth_rx_er = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge eth_rx_clk);
            #1;
            eth_rx_dv = 1'b0;
            eth_rx_er = 1'b0;
            eth_rxd   = 8'h00;
        end
    endtask

    // Pushes the expected output of the current frame, then drives it on GMII.
    task automatic send_frame(input bit accept, input int er_idx, input int gap);
        int L, P, ab, n;
        bit good;
        L    = fr.size();
        P    = L - 18;
        ab   = er_idx;
        if (L > MAX_LEN && (ab < 0 || ab > MAX_LEN - 14)) ab = MAX_LEN - 14;
        good = !fr_bad && (L >= MIN_LEN);
        if (accept) begin
            n = (ab >= 0) ? ((ab > 4) ? ab - 4 : 0) : P;
            for (int j = 0; j < n; j++) exp_q.push_back('{d: fr[14+j], sof: (j == 0)});
            if (n > 0) eof_q.push_back((ab >= 0) ? 1'b0 : good);
        end
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < L; i++) drive(fr[i], (er_idx >= 0) && (i - 14 == er_idx));
        idle(gap);
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        repeat (3) @(negedge eth_rx_clk);
        vectors++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_good} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %h, required 000", {rx_data, rx_valid, rx_sof, rx_eof, rx_good});
        end
        vectors++;
        if (rx_src_mac !== 48'h0 || rx_ethertype !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_hdr: got %h/%h, required 0/0", rx_src_mac, rx_ethertype);
        end
        vectors++;
        if (crc_err_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d, required 0", crc_err_cnt);
        end
        @(posedge eth_rx_clk);
        #1 arst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_min_frame;
        build(MAC, 48'h0a0b0c0d0e0f, 16'h0800, 46, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL min_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (rx_src_mac !== 48'h0a0b0c0d0e0f || rx_ethertype !== 16'h0800) begin
            miscompares++;
            $display("FAIL min_hdr: got %h/%h, required 0a0b0c0d0e0f/0800", rx_src_mac, rx_ethertype);
        end
        vectors++;
        if (crc_err_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL min_cnt: got %0d, required 0", crc_err_cnt);
        end
    endtask

    task automatic test_bad_fcs;
        build(MAC, 48'h0a0b0c0d0e0f, 16'h0800, 46, 1'b1);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL badfcs_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (crc_err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL badfcs_cnt: got %0d, required 1", crc_err_cnt);
        end
    endtask

    task automatic test_filter;
        int s0, g0;
        s0 = p_sof_cnt;
        g0 = p_good_cnt;
        build(48'h020000000001, 48'h111111111111, 16'h0806, 46, 1'b0);
        send_frame(1'b0, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (p_sof_cnt - s0 != 1 || p_good_cnt - g0 != 1) begin
            miscompares++;
            $display("FAIL promisc_accept: got sof %0d good %0d, required 1 1", p_sof_cnt - s0, p_good_cnt - g0);
        end
        vectors++;
        if (rx_src_mac !== 48'h0a0b0c0d0e0f) begin
            miscompares++;
            $display("FAIL filter_hdr_kept: got %h, required 0a0b0c0d0e0f", rx_src_mac);
        end
    endtask

    task automatic test_broadcast;
        build(48'hFFFFFFFFFFFF, 48'h222222222222, 16'h0806, 50, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL bcast_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (rx_src_mac !== 48'h222222222222 || rx_ethertype !== 16'h0806) begin
            miscompares++;
            $display("FAIL bcast_hdr: got %h/%h, required 222222222222/0806", rx_src_mac, rx_ethertype);
        end
    endtask

    task automatic test_runt;
        build(MAC, 48'h333333333333, 16'h0800, 42, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL runt_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (crc_err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL runt_cnt: got %0d, required 1", crc_err_cnt);
        end
    endtask

    task automatic test_back_to_back;
        build(MAC, 48'h444444444444, 16'h0800, 47, 1'b0);
        send_frame(1'b1, -1, 1);
        build(MAC, 48'h555555555555, 16'h86DD, 60, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (rx_src_mac !== 48'h555555555555 || rx_ethertype !== 16'h86DD) begin
            miscompares++;
            $display("FAIL b2b_hdr: got %h/%h, required 555555555555/86dd", rx_src_mac, rx_ethertype);
        end
    endtask

    task automatic test_er_abort;
        build(MAC, 48'h666666666666, 16'h0800, 100, 1'b0);
        send_frame(1'b1, 20, 4);
        build(MAC, 48'h777777777777, 16'h0800, 46, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL er_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (rx_src_mac !== 48'h777777777777) begin
            miscompares++;
            $display("FAIL er_next_hdr: got %h, required 777777777777", rx_src_mac);
        end
    endtask

    task automatic test_long;
        build(MAC, 48'h888888888888, 16'h0800, 1512, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL long_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
    endtask

    task automatic test_reset_mid;
        build(MAC, 48'h999999999999, 16'h0800, 80, 1'b0);
        mon_en = 1'b0;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 44; i++) drive(fr[i], 1'b0);
        #2;
        vectors++;
        if (rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_inflight: got rx_valid %b, required 1", rx_valid);
        end
        arst_n = 1'b0;
        #1;
        vectors++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_good} !== 12'h000) begin
            miscompares++;
            $display("FAIL rstmid_ctrl: got %h, required 000", {rx_data, rx_valid, rx_sof, rx_eof, rx_good});
        end
        vectors++;
        if (rx_src_mac !== 48'h0 || crc_err_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_state: got %h/%0d, required 0/0", rx_src_mac, crc_err_cnt);
        end
        #1 arst_n = 1'b1;
        act_cnt = 0;
        for (int i = 44; i < fr.size(); i++) drive(fr[i], 1'b0);
        idle(4);
        repeat (4) @(negedge eth_rx_clk);
        vectors++;
        if (act_cnt != 0) begin
            miscompares++;
            $display("FAIL rstmid_ignored: got %0d output cycles, required 0", act_cnt);
        end
        mon_en = 1'b1;
        build(MAC, 48'haaaaaaaaaaaa, 16'h0800, 46, 1'b0);
        send_frame(1'b1, -1, 4);
        repeat (6) @(negedge eth_rx_clk);
        vectors++;
        if (exp_q.size() != 0 || eof_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_drain: got %0d bytes %0d eofs outstanding, required 0 0", exp_q.size(), eof_q.size());
        end
        vectors++;
        if (rx_src_mac !== 48'haaaaaaaaaaaa || crc_err_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_next: got %h/%0d, required aaaaaaaaaaaa/0", rx_src_mac, crc_err_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_min_frame;
        test_bad_fcs;
        test_filter;
        test_broadcast;
        test_runt;
        test_back_to_back;
        test_er_abort;
        test_long;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
